// File: rtl/pattern_sweeper_if.sv
// Host/DUT-facing bundle of the pattern sweeper: sweep handshake, DUT stimulus/response
// and compacted results. master = bench/host side, slave = sweeper.
interface pattern_sweeper_if #(
  parameter int PI_W  = 8,
  parameter int SIG_W = 16
);
  logic             start;
  logic             pause;
  logic             ack;
  logic             po_in;
  logic [PI_W-1:0]  pi_out;
  logic             busy;
  logic             done;
  logic [SIG_W-1:0] signature;
  logic [PI_W:0]    ones;

  modport master (
    output start, pause, ack, po_in,
    input  pi_out, busy, done, signature, ones
  );

  modport slave (
    input  start, pause, ack, po_in,
    output pi_out, busy, done, signature, ones
  );
endinterface

// File: rtl/pattern_sweeper.sv
// Exhaustive stimulus sweep for an 8-in/1-out netlist with CRC/ones-count response compaction.
// Define PATTERN_SWEEPER_GRAY_EN to issue vectors in Gray order instead of binary order.
module pattern_sweeper #(
  parameter int PI_W  = 8,
  parameter int LAT   = 0,
  parameter int SIG_W = 16
) (
  input logic clk,
  input logic rst_n,
  pattern_sweeper_if.slave bus
);
  localparam int N = 1 << PI_W;
  localparam logic [SIG_W-1:0] POLY = 16'h1021;
  localparam logic [SIG_W-1:0] SEED = 16'hFFFF;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t           state_reg, state_next;
  logic [PI_W:0]    cnt_reg, cnt_next;
  logic [PI_W-1:0]  pi_reg, pi_next;
  logic [LAT:0]     vld_reg, vld_next;
  logic [SIG_W-1:0] sig_reg, sig_next;
  logic [PI_W:0]    ones_reg, ones_next;
  logic             active, advance, issue, cap, fb;

  function automatic logic [PI_W-1:0] seq(input logic [PI_W-1:0] k);
`ifdef PATTERN_SWEEPER_GRAY_EN
    return k ^ (k >> 1);
`else
    return k;
`endif
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      pi_reg    <= '0;
      vld_reg   <= '0;
      sig_reg   <= SEED;
      ones_reg  <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      pi_reg    <= pi_next;
      vld_reg   <= vld_next;
      sig_reg   <= sig_next;
      ones_reg  <= ones_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    pi_next    = pi_reg;
    vld_next   = vld_reg;
    sig_next   = sig_reg;
    ones_next  = ones_reg;

    active  = (state_reg == RUN) || (state_reg == DRAIN);
    advance = active && !bus.pause;
    // cnt_reg[PI_W] set means every vector has already been issued
    issue   = (state_reg == RUN) && advance && !cnt_reg[PI_W];
    cap     = advance && vld_reg[LAT];
    fb      = sig_reg[SIG_W-1] ^ bus.po_in;

    // Bit i of the valid pipe marks a vector that has been on pi_out for i cycles.
    if (advance)
      vld_next = (vld_reg << 1) | (LAT+1)'(issue);

    if (cap) begin
      sig_next  = {sig_reg[SIG_W-2:0], 1'b0} ^ (fb ? POLY : '0);
      ones_next = ones_reg + (PI_W+1)'(bus.po_in);
    end

    if (issue) begin
      pi_next  = seq(cnt_reg[PI_W-1:0]);
      cnt_next = cnt_reg + 1'b1;
    end

    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          sig_next   = SEED;
          ones_next  = '0;
          cnt_next   = '0;
          vld_next   = '0;
          state_next = RUN;
        end
      end
      RUN: begin
        // A combinational DUT has no tokens in flight, so RUN finishes on its own last capture.
        if (issue && (cnt_reg == (PI_W+1)'(N-1)) && (LAT != 0))
          state_next = DRAIN;
        else if (advance && cnt_reg[PI_W] && (vld_next == '0))
          state_next = DONE;
      end
      DRAIN: begin
        if (advance && (vld_next == '0))
          state_next = DONE;
      end
      DONE: begin
        if (bus.ack)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.pi_out    = pi_reg;
  assign bus.busy      = active;
  assign bus.done      = (state_reg == DONE);
  assign bus.signature = sig_reg;
  assign bus.ones      = ones_reg;
endmodule

// File: doc/pattern_sweeper.md
Name: pattern_sweeper

Overview:
- Sequential stimulus/response harness for the other end of the team's 8-in/1-out combinational benchmark netlists.
- Drives every input vector onto the pi bus and collects the DUT's po response. For FCN-mapped netlists, the response arrives after a fixed clock-zone latency.
- Compacts the responses into a CRC signature and a ones count.
- Sits between a bench/host controller and the mapped DUT, with a start/done/ack handshake toward the host.

Parameters:
- PI_W, 8: DUT input width; sweep length N = 2^PI_W.
- LAT, 0: DUT response latency in clk cycles, 0..15. 0 means a purely combinational DUT.
- SIG_W, 16: signature width. POLY is fixed 16'h1021 and SEED is fixed 16'hFFFF; only SIG_W=16 is supported.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins a sweep when in IDLE
- pause  in  1  stalls the vector advance and its capture (hold)
- po_in  in  1  DUT output
- pi_out  out  PI_W  registered DUT input vector
- busy  out  1  high in RUN or DRAIN
- done  out  1  results valid; held until ack
- ack  in  1  host has consumed the results; returns to IDLE
- signature  out  SIG_W  CRC of the response stream
- ones  out  PI_W+1  count of po_in==1 responses

Behaviour:
- Reset (async assert, sync release) clears these: state=IDLE, pi_out=0, busy=0, done=0, signature=SEED, ones=0, internal vector counter=0, valid pipe=0.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - On start, clear signature to SEED, ones to 0, and counter to 0, then go to RUN.
  - start is ignored in every other state.
- RUN:
  - On each cycle with pause=0, pi_out <= sequence(counter) and counter increments.
  - A valid token enters a LAT-deep pipe, aligned so that vector k, driven on pi_out in cycle t, is sampled from po_in at the rising edge ending cycle t+LAT.
  - After the last vector (counter==N-1 issued), go to DRAIN.
- pause=1 freezes these: counter, pi_out, valid pipe and accumulation. A FCN DUT held at constant input keeps the pipe consistent.
- Capture, on each valid sample:
  - fb = signature[15] ^ po_in.
  - signature <= (signature<<1) ^ (fb ? POLY : 0).
  - ones <= ones + po_in.
- DRAIN:
  - Continue capturing until the valid pipe is empty, then go to DONE with done=1.
  - With LAT=0, go from the last RUN capture directly to DONE.
- DONE:
  - signature and ones stay stable and pi_out holds the last vector.
  - ack gives done=0 and IDLE on the next edge.
  - ack outside DONE is ignored.
- Latency: with pause never asserted, done rises exactly N+LAT+1 cycles after the start edge.
- ones is PI_W+1 wide, so the all-ones sweep gives N=256 with no overflow.
- Counter wrap: the counter never wraps during a sweep. It is reset by start.
- Reset during RUN or DRAIN aborts the sweep with no done.
- start together with ack in DONE: ack wins; start is ignored.

Optional Feature:
- Macro: PATTERN_SWEEPER_GRAY_EN.
- When defined: sequence(k) = k ^ (k>>1), Gray order. One pi bit toggles per vector, which reduces FCN switching stress.
- When undefined: sequence(k) = k, binary order.
- ones is order-independent and identical in both builds. signature differs between the builds.

Test Plan:
- Constant DUT, po_in tied to 1, LAT=0, no pause -> done exactly 257 cycles after start; ones=256; signature matches the bench CRC model.
- DUT po = pi_out[0] -> ones=128. DUT po = pi_out[7]&pi_out[6] -> ones=64. signature matches the model for each.
- LAT=3, with po_in fed through a 3-stage delay of pi_out[0] -> ones=128; done at cycle N+4; the sample from the first vector is po for vector 0.
- pause asserted for 10 random windows in RUN -> identical ones/signature to an unpaused run; done delayed by the total pause cycles.
- rst_n pulled low at vector 100 -> all outputs at their reset values immediately. A fresh start then gives full correct results.
- In DONE, assert start without ack -> no change. Assert ack -> done=0 and IDLE next cycle. Under PATTERN_SWEEPER_GRAY_EN, consecutive pi_out values differ in exactly one bit.
